traffic_phase_ctrl: RTL and testbench

Parametrised N-approach traffic-light sequencer. It generalises the two-group controller to N_PHASE approaches, with per-phase green times, a shared yellow time and an optional all-red clearance interval. It adds a blinking night mode and saturating key-based configuration. It sits between the clock divider (which supplies the 1 s tick) and the lamp and seven-segment drivers.

---
 rtl/traffic_pkg.sv | 40 ++++
 rtl/key_pulse_sync.sv | 26 ++
 rtl/traffic_phase_ctrl.sv | 179 +++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings and saturating arithmetic for the traffic phase controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_NIGHT  = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_ALLRED = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_NIGHT = 2'd1,
        MODE_SET_G = 2'd2,
        MODE_SET_Y = 2'd3
    } mode_e;

    localparam int SAT_W = 32;

    // a+b clamped to hi, or a-b clamped to lo; callers size operands to SAT_W.
    function automatic logic [SAT_W-1:0] sat_addsub(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input logic             sub,
        input logic [SAT_W-1:0] lo,
        input logic [SAT_W-1:0] hi
    );
        logic [SAT_W:0]   w_sum;
        logic [SAT_W-1:0] w_res;
        w_sum = {1'b0, a} + {1'b0, b};
        w_res = w_sum[SAT_W-1:0];
        if (sub) begin
            w_res = ({1'b0, a} < ({1'b0, lo} + {1'b0, b})) ? lo : (a - b);
        end else if (w_sum > {1'b0, hi}) begin
            w_res = hi;
        end
        return w_res;
    endfunction

endpackage

// File: rtl/key_pulse_sync.sv
// Two-flop synchroniser for a raw key level followed by a rising-edge detector.
module key_pulse_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_pulse
);
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-approach traffic-light sequencer: green/yellow/all-red rotation, blinking
// night mode and key-driven editing of the green and yellow durations.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int N_PHASE        = 2,
    parameter int CNT_W          = 11,
    parameter int GREEN_DEFAULT  = 8,
    parameter int YELLOW_DEFAULT = 6,
    parameter int ALLRED_TIME    = 1,
    parameter int SEL_W          = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [1:0]         mode,
    input  logic               key_plus,
    input  logic               key_sub,
    input  logic [SEL_W-1:0]   sel_phase,
    output logic [N_PHASE-1:0] red,
    output logic [N_PHASE-1:0] yellow,
    output logic [N_PHASE-1:0] green,
    output logic [SEL_W-1:0]   active_phase,
    output logic [CNT_W-1:0]   remain,
    output logic [CNT_W-1:0]   disp_val
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [SAT_W-1:0] SAT_MAX = SAT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_e             r_state, w_state_nx;
    mode_e              w_mode;
    logic [SEL_W-1:0]   r_phase, w_phase_nx, w_phase_inc;
    logic [CNT_W-1:0]   r_remain, w_remain_nx;
    logic               r_blink, w_blink_nx;
    logic [CNT_W-1:0]   r_green_time [N_PHASE];
    logic [CNT_W-1:0]   r_yellow_time;
    logic [CNT_W-1:0]   w_green_sel, w_green_inc, w_green_edit, w_yellow_edit;
    logic [N_PHASE-1:0] w_phase_oh;
    logic [N_PHASE-1:0] r_red, r_yellow, r_green;
    logic               w_plus, w_sub, w_edit;

    // A zero duration would never see remain reach 1, so it runs as one tick.
    function automatic logic [CNT_W-1:0] load_dur(input logic [CNT_W-1:0] d);
        return (d == '0) ? ONE : d;
    endfunction

    key_pulse_sync u_key_plus (.i_clk(clk), .i_rst(rst), .i_key(key_plus), .o_pulse(w_plus));
    key_pulse_sync u_key_sub  (.i_clk(clk), .i_rst(rst), .i_key(key_sub),  .o_pulse(w_sub));

    assign w_mode      = mode_e'(mode);
    assign w_edit      = w_plus ^ w_sub;
    assign w_phase_inc = (r_phase == SEL_W'(N_PHASE - 1)) ? '0 : r_phase + SEL_W'(1);

    always_comb begin
        w_green_sel = '0;
        w_green_inc = '0;
        w_phase_oh  = '0;
        for (int i = 0; i < N_PHASE; i++) begin
            if (sel_phase == SEL_W'(i))   w_green_sel   = r_green_time[i];
            if (w_phase_inc == SEL_W'(i)) w_green_inc   = r_green_time[i];
            if (r_phase == SEL_W'(i))     w_phase_oh[i] = 1'b1;
        end
    end

    assign w_green_edit  = CNT_W'(sat_addsub(SAT_W'(w_green_sel), SAT_W'(1), w_sub,
                                             SAT_W'(1), SAT_MAX));
    assign w_yellow_edit = CNT_W'(sat_addsub(SAT_W'(r_yellow_time), SAT_W'(1), w_sub,
                                             SAT_W'(1), SAT_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PHASE; i++) r_green_time[i] <= CNT_W'(GREEN_DEFAULT);
            r_yellow_time <= CNT_W'(YELLOW_DEFAULT);
        end else if (w_edit) begin
            for (int i = 0; i < N_PHASE; i++) begin
                if (w_mode == MODE_SET_G && sel_phase == SEL_W'(i)) r_green_time[i] <= w_green_edit;
            end
            if (w_mode == MODE_SET_Y) r_yellow_time <= w_yellow_edit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_NIGHT;
            r_phase  <= '0;
            r_remain <= '0;
            r_blink  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_phase  <= w_phase_nx;
            r_remain <= w_remain_nx;
            r_blink  <= w_blink_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_phase_nx  = r_phase;
        w_remain_nx = r_remain;
        w_blink_nx  = 1'b0;
        if (w_mode == MODE_NIGHT) begin
            w_state_nx  = ST_NIGHT;
            w_phase_nx  = '0;
            w_remain_nx = '0;
            w_blink_nx  = (r_state == ST_NIGHT) ? (r_blink ^ tick) : 1'b0;
        end else if (r_state == ST_NIGHT) begin
            if (w_mode == MODE_RUN) begin
                w_state_nx  = ST_GREEN;
                w_phase_nx  = '0;
                w_remain_nx = load_dur(r_green_time[0]);
            end else begin
                w_blink_nx = r_blink ^ tick;
            end
        end else if (w_mode == MODE_RUN && tick) begin
            if (r_remain > ONE) begin
                w_remain_nx = r_remain - ONE;
            end else begin
                case (r_state)
                    ST_GREEN: begin
                        w_state_nx  = ST_YELLOW;
                        w_remain_nx = load_dur(r_yellow_time);
                    end
                    ST_YELLOW: begin
                        if (ALLRED_TIME > 0) begin
                            w_state_nx  = ST_ALLRED;
                            w_remain_nx = load_dur(CNT_W'(ALLRED_TIME));
                        end else begin
                            w_state_nx  = ST_GREEN;
                            w_phase_nx  = w_phase_inc;
                            w_remain_nx = load_dur(w_green_inc);
                        end
                    end
                    default: begin
                        w_state_nx  = ST_GREEN;
                        w_phase_nx  = w_phase_inc;
                        w_remain_nx = load_dur(w_green_inc);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_red    <= '0;
            r_yellow <= '0;
            r_green  <= '0;
        end else begin
            r_red    <= '0;
            r_yellow <= '0;
            r_green  <= '0;
            case (r_state)
                ST_NIGHT:  r_yellow <= {N_PHASE{r_blink}};
                ST_GREEN:  begin r_green  <= w_phase_oh; r_red <= ~w_phase_oh; end
                ST_YELLOW: begin r_yellow <= w_phase_oh; r_red <= ~w_phase_oh; end
                default:   r_red <= '1;
            endcase
        end
    end

    always_comb begin
        case (w_mode)
            MODE_SET_G: disp_val = w_green_sel;
            MODE_SET_Y: disp_val = r_yellow_time;
            default:    disp_val = (r_state == ST_GREEN)
                                   ? CNT_W'(sat_addsub(SAT_W'(r_remain), SAT_W'(r_yellow_time),
                                                       1'b0, '0, SAT_MAX))
                                   : r_remain;
        endcase
    end

    assign red          = r_red;
    assign yellow       = r_yellow;
    assign green        = r_green;
    assign active_phase = r_phase;
    assign remain       = r_remain;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: a step-level model checked every cycle on the
// default build, plus directed checks on a narrow-counter and a 3-phase build.
module tb_traffic_phase_ctrl;
    localparam int N      = 2;
    localparam int W      = 11;
    localparam int MAXV   = (1 << W) - 1;
    localparam int ALLRED = 1;
    localparam int K_NIGHT = 0, K_GREEN = 1, K_YELLOW = 2, K_ALLRED = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rst_x = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] mode = 2'b01;
    logic       key_plus = 1'b0;
    logic       key_sub = 1'b0;
    logic [1:0] sel_phase = 2'd0;

    logic [1:0]  red, yellow, green, active_phase;
    logic [10:0] remain, disp_val;
    logic [1:0]  red_s, yellow_s, green_s, active_s;
    logic [3:0]  remain_s, disp_s;
    logic [2:0]  red3, yellow3, green3;
    logic [1:0]  active3;
    logic [10:0] remain3, disp3;

    int errors = 0;
    int checks = 0;

    traffic_phase_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick), .mode(mode), .key_plus(key_plus),
        .key_sub(key_sub), .sel_phase(sel_phase), .red(red), .yellow(yellow),
        .green(green), .active_phase(active_phase), .remain(remain), .disp_val(disp_val)
    );

    traffic_phase_ctrl #(.N_PHASE(2), .CNT_W(4), .GREEN_DEFAULT(15), .YELLOW_DEFAULT(6),
                         .ALLRED_TIME(1), .SEL_W(2)) dut_s (
        .clk(clk), .rst(rst_x), .tick(tick), .mode(mode), .key_plus(key_plus),
        .key_sub(key_sub), .sel_phase(sel_phase), .red(red_s), .yellow(yellow_s),
        .green(green_s), .active_phase(active_s), .remain(remain_s), .disp_val(disp_s)
    );

    traffic_phase_ctrl #(.N_PHASE(3), .CNT_W(11), .GREEN_DEFAULT(2), .YELLOW_DEFAULT(1),
                         .ALLRED_TIME(0), .SEL_W(2)) dut3 (
        .clk(clk), .rst(rst_x), .tick(tick), .mode(mode), .key_plus(key_plus),
        .key_sub(key_sub), .sel_phase(sel_phase), .red(red3), .yellow(yellow3),
        .green(green3), .active_phase(active3), .remain(remain3), .disp_val(disp3)
    );

    // clock / reset
    always #5 clk = ~clk;

    // step-level model of the default build
    bit m_valid = 1'b0;
    int m_kind, m_phase, m_remain, m_blink, m_yt;
    int m_gt [N];
    int m_red, m_yel, m_grn;
    bit p_h [3];
    bit s_h [3];
    bit pp, sp;

    function automatic int at_least_one(input int d);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic int exp_disp();
        if (mode == 2'd2) return (sel_phase < N) ? m_gt[sel_phase] : 0;
        if (mode == 2'd3) return m_yt;
        if (m_kind == K_GREEN) return (m_remain + m_yt > MAXV) ? MAXV : m_remain + m_yt;
        return m_remain;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_kind = K_NIGHT; m_phase = 0; m_remain = 0; m_blink = 0;
            for (int i = 0; i < N; i++) m_gt[i] = 8;
            m_yt = 6;
            m_red = 0; m_yel = 0; m_grn = 0;
            for (int i = 0; i < 3; i++) begin p_h[i] = 1'b0; s_h[i] = 1'b0; end
        end else if (m_valid) begin
            // lamps show the step that was held up to this edge
            m_grn = (m_kind == K_GREEN)  ? (1 << m_phase) : 0;
            m_yel = (m_kind == K_YELLOW) ? (1 << m_phase) : (m_kind == K_NIGHT && m_blink != 0) ? 3 : 0;
            m_red = (m_kind == K_ALLRED) ? 3 : (m_kind == K_NIGHT) ? 0 : (3 & ~(1 << m_phase));
            pp = p_h[1] && !p_h[2];
            sp = s_h[1] && !s_h[2];
            p_h[2] = p_h[1]; p_h[1] = p_h[0]; p_h[0] = key_plus;
            s_h[2] = s_h[1]; s_h[1] = s_h[0]; s_h[0] = key_sub;
            if (mode == 2'd1) begin
                m_blink = (m_kind == K_NIGHT) ? (m_blink ^ int'(tick)) : 0;
                m_kind = K_NIGHT; m_phase = 0; m_remain = 0;
            end else if (m_kind == K_NIGHT) begin
                if (mode == 2'd0) begin
                    m_kind = K_GREEN; m_phase = 0; m_remain = at_least_one(m_gt[0]); m_blink = 0;
                end else if (tick) begin
                    m_blink = 1 - m_blink;
                end
            end else if (mode == 2'd0 && tick) begin
                if (m_remain > 1) begin
                    m_remain = m_remain - 1;
                end else if (m_kind == K_GREEN) begin
                    m_kind = K_YELLOW; m_remain = at_least_one(m_yt);
                end else if (m_kind == K_YELLOW && ALLRED > 0) begin
                    m_kind = K_ALLRED; m_remain = ALLRED;
                end else begin
                    m_kind = K_GREEN; m_phase = (m_phase + 1) % N;
                    m_remain = at_least_one(m_gt[m_phase]);
                end
            end
            if (pp != sp) begin
                if (mode == 2'd2 && sel_phase < N)
                    m_gt[sel_phase] = pp ? ((m_gt[sel_phase] >= MAXV) ? MAXV : m_gt[sel_phase] + 1)
                                         : ((m_gt[sel_phase] <= 2) ? 1 : m_gt[sel_phase] - 1);
                if (mode == 2'd3)
                    m_yt = pp ? ((m_yt >= MAXV) ? MAXV : m_yt + 1) : ((m_yt <= 2) ? 1 : m_yt - 1);
            end
        end
    end

    // scoreboard
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid && !rst) begin
            chk("model_red", int'(red), m_red);
            chk("model_yellow", int'(yellow), m_yel);
            chk("model_green", int'(green), m_grn);
            chk("model_active", int'(active_phase), m_phase);
            chk("model_remain", int'(remain), m_remain);
            chk("model_disp", int'(disp_val), exp_disp());
        end
    end

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc(); cyc(); cyc();
        end
    endtask

    task automatic press_plus();
        key_plus = 1'b1; cyc(); cyc();
        key_plus = 1'b0; cyc(); cyc();
    endtask

    task automatic press_sub();
        key_sub = 1'b1; cyc(); cyc();
        key_sub = 1'b0; cyc(); cyc();
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1 rst = 1'b1; rst_x = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        chk("reset_remain", int'(remain), 0);
        chk("reset_active", int'(active_phase), 0);
        chk("reset_lamps", int'({red, yellow, green}), 0);

        // run sequence: G0 8, Y0 6, AR 1, G1 ...
        mode = 2'd0; cyc();
        chk("g0_entry_remain", int'(remain), 8);
        chk("g0_entry_disp", int'(disp_val), 14);
        cyc();
        chk("g0_green", int'(green), 1);
        chk("g0_red", int'(red), 2);
        ticks(8);
        chk("y0_yellow", int'(yellow), 1);
        chk("y0_remain", int'(remain), 6);
        ticks(6);
        chk("allred_red", int'(red), 3);
        chk("allred_remain", int'(remain), 1);
        ticks(1);
        chk("g1_green", int'(green), 2);
        chk("g1_active", int'(active_phase), 1);
        ticks(15);
        chk("cycle30_active", int'(active_phase), 0);
        chk("cycle30_remain", int'(remain), 8);

        // night mode from mid-GREEN(1)
        ticks(18);
        chk("g1_mid_remain", int'(remain), 5);
        mode = 2'd1; cyc();
        chk("night_remain", int'(remain), 0);
        chk("night_active", int'(active_phase), 0);
        cyc();
        chk("night_red_green", int'({red, green}), 0);
        ticks(1);
        chk("blink_on", int'(yellow), 3);
        ticks(1);
        chk("blink_off", int'(yellow), 0);
        ticks(1);
        chk("blink_on2", int'(yellow), 3);

        // edit green_time[1] while a phase-1 countdown is frozen
        mode = 2'd0; cyc();
        ticks(17);
        chk("g1_run_remain", int'(remain), 6);
        mode = 2'd2; sel_phase = 2'd1; cyc();
        chk("setg_disp", int'(disp_val), 8);
        repeat (10) press_plus();
        cyc();
        chk("setg_disp_18", int'(disp_val), 18);
        ticks(1);
        chk("frozen_remain", int'(remain), 6);
        mode = 2'd0;
        ticks(5);
        chk("old_len_remain", int'(remain), 1);
        ticks(1);
        chk("old_len_yellow", int'(yellow), 2);
        ticks(22);
        chk("new_g1_remain", int'(remain), 18);
        chk("new_g1_disp", int'(disp_val), 24);

        // held key and simultaneous keys
        mode = 2'd2; sel_phase = 2'd1;
        key_plus = 1'b1; repeat (10) cyc();
        key_plus = 1'b0; cyc(); cyc();
        chk("held_key", int'(disp_val), 19);
        key_plus = 1'b1; key_sub = 1'b1; repeat (3) cyc();
        key_plus = 1'b0; key_sub = 1'b0; repeat (3) cyc();
        chk("both_keys", int'(disp_val), 19);

        // yellow floor and out-of-range selector
        mode = 2'd3; cyc();
        chk("sety_disp", int'(disp_val), 6);
        repeat (5) press_sub();
        chk("yellow_1", int'(disp_val), 1);
        repeat (3) press_sub();
        chk("yellow_floor", int'(disp_val), 1);
        mode = 2'd2; sel_phase = 2'd3; cyc();
        chk("sel_oor_disp", int'(disp_val), 0);
        press_plus();
        sel_phase = 2'd0; cyc();
        chk("sel_oor_g0", int'(disp_val), 8);
        sel_phase = 2'd1; cyc();
        chk("sel_oor_g1", int'(disp_val), 19);
        mode = 2'd0;
        ticks(18);
        chk("short_yellow_remain", int'(remain), 1);
        ticks(2);
        chk("after_short_yellow", int'(remain), 8);

        // narrow-counter and three-phase builds
        rst_x = 1'b0;
        cyc();
        chk("sat_remain", int'(remain_s), 15);
        chk("sat_disp", int'(disp_s), 15);
        chk("p3_remain", int'(remain3), 2);
        cyc();
        chk("p3_g0", int'(green3), 1);
        for (int s = 0; s < 6; s++) begin
            ticks((s % 2 == 0) ? 2 : 1);
            chk("p3_green", int'(green3), ((s + 1) % 2 == 0) ? (1 << (((s + 1) / 2) % 3)) : 0);
            chk("p3_yellow", int'(yellow3), ((s + 1) % 2 == 1) ? (1 << (((s + 1) / 2) % 3)) : 0);
            chk("p3_red", int'(red3), 7 & ~(1 << (((s + 1) / 2) % 3)));
            chk("p3_active", int'(active3), ((s + 1) / 2) % 3);
        end
        mode = 2'd2; sel_phase = 2'd0; cyc();
        chk("sat_setg", int'(disp_s), 15);
        press_plus();
        chk("sat_plus", int'(disp_s), 15);
        press_sub();
        chk("sat_sub", int'(disp_s), 14);
        mode = 2'd0;
        ticks(1);
        chk("p3_mid_green", int'(green3), 1);
        #1 rst_x = 1'b1;
        #1;
        chk("async_rst_lamps", int'({red3, yellow3, green3}), 0);
        chk("async_rst_remain", int'(remain3), 0);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
